// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with run-time seeding, zero-seed lockup recovery
// and optional period measurement (enabled by defining LFSR_PERIOD_EN).
module lfsr_gen #(
  parameter int unsigned            WIDTH = 8,
  parameter int unsigned            OUT_W = 5,
  parameter logic [WIDTH-1:0]       TAPS  = 8'b1110_0001,
  parameter logic [WIDTH-1:0]       SEED  = 8'h01
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             next_i,
  input  logic             seed_valid_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [OUT_W-1:0] rand_o,
  output logic [WIDTH-1:0] state_o,
  output logic             lockup_o,
  output logic             wrap_o,
  output logic [WIDTH-1:0] period_o,
  output logic             period_valid_o
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] next_val;
  logic [WIDTH-1:0] seed_eff;
  logic             seed_zero;

  assign next_val  = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
  assign seed_zero = (seed_i == '0);
  // An all-zero state would lock the LFSR, so substitute the reset seed.
  assign seed_eff  = seed_zero ? SEED : seed_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= SEED;
      lockup_o <= 1'b0;
    end else begin
      lockup_o <= 1'b0;
      if (seed_valid_i) begin
        state_q  <= seed_eff;
        lockup_o <= seed_zero;
      end else if (next_i) begin
        state_q <= next_val;
      end
    end
  end

  assign state_o = state_q;
  assign rand_o  = state_q[OUT_W-1:0];

`ifdef LFSR_PERIOD_EN
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      start_q        <= SEED;
      cnt_q          <= '0;
      wrap_o         <= 1'b0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
    end else begin
      wrap_o <= 1'b0;
      if (seed_valid_i) begin
        start_q        <= seed_eff;
        cnt_q          <= '0;
        period_valid_o <= 1'b0;
      end else if (next_i) begin
        if (next_val == start_q) begin
          wrap_o         <= 1'b1;
          period_o       <= cnt_q + 1'b1;
          period_valid_o <= 1'b1;
          cnt_q          <= '0;
        end else if (cnt_q != '1) begin
          // Saturate so a non-returning tap set never fakes a wrap.
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end
`else
  assign wrap_o         = 1'b0;
  assign period_o       = '0;
  assign period_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: default 8-bit instance plus a 4-bit
// maximal-length instance used for wrap/period behaviour.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       next8, seed_valid8;
  logic [7:0] seed8;
  logic       next4, seed_valid4;
  logic [3:0] seed4;

  logic [4:0] rand8;
  logic [7:0] state8, period8;
  logic       lockup8, wrap8, pvalid8;
  logic [3:0] rand4, state4, period4;
  logic       lockup4, wrap4, pvalid4;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  lfsr_gen u8 (
    .clk_i(clk), .rst_ni(rst_n), .next_i(next8), .seed_valid_i(seed_valid8),
    .seed_i(seed8), .rand_o(rand8), .state_o(state8), .lockup_o(lockup8),
    .wrap_o(wrap8), .period_o(period8), .period_valid_o(pvalid8)
  );

  lfsr_gen #(.WIDTH(4), .OUT_W(4), .TAPS(4'b1001), .SEED(4'h1)) u4 (
    .clk_i(clk), .rst_ni(rst_n), .next_i(next4), .seed_valid_i(seed_valid4),
    .seed_i(seed4), .rand_o(rand4), .state_o(state4), .lockup_o(lockup4),
    .wrap_o(wrap4), .period_o(period4), .period_valid_o(pvalid4)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] seq4 [15];
  logic [3:0] exp_state;

  initial begin
    seq4 = '{4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5, 4'hB,
             4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1};
    rst_n = 1'b0; next8 = 1'b0; seed_valid8 = 1'b0; seed8 = '0;
    next4 = 1'b0; seed_valid4 = 1'b0; seed4 = '0;
    tick(); tick();
    chk("rst_state8", state8, 8'h01);
    chk("rst_rand8", {3'b0, rand8}, 8'h01);
    chk("rst_lockup8", {7'b0, lockup8}, 8'h00);
    chk("rst_wrap8", {7'b0, wrap8}, 8'h00);
    chk("rst_period8", period8, 8'h00);
    chk("rst_pvalid8", {7'b0, pvalid8}, 8'h00);
    chk("rst_state4", {4'b0, state4}, 8'h01);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("hold_state8_%0d", i), state8, 8'h01);
      chk($sformatf("hold_pulses8_%0d", i), {6'b0, lockup8, wrap8}, 8'h00);
    end

    next8 = 1'b1;
    tick();
    chk("step1_state8", state8, 8'h03);
    chk("step1_rand8", {3'b0, rand8}, 8'h03);
    tick();
    chk("step2_state8", state8, 8'h07);
    chk("step2_rand8", {3'b0, rand8}, 8'h07);

    // Zero seed with next_i: load wins, SEED substituted, no step.
    seed_valid8 = 1'b1; seed8 = 8'h00;
    tick();
    chk("zseed_state8", state8, 8'h01);
    chk("zseed_lockup8", {7'b0, lockup8}, 8'h01);
    seed_valid8 = 1'b0; next8 = 1'b0;
    tick();
    chk("zseed_hold_state8", state8, 8'h01);
    chk("zseed_lockup_clear8", {7'b0, lockup8}, 8'h00);

    seed_valid8 = 1'b1; seed8 = 8'hA5; next8 = 1'b1;
    tick();
    chk("seedA5_state8", state8, 8'hA5);
    chk("seedA5_lockup8", {7'b0, lockup8}, 8'h00);
    chk("seedA5_pvalid8", {7'b0, pvalid8}, 8'h00);
    seed_valid8 = 1'b0;
    // A5 & E1 = A1: bits 7,5,0 set, feedback 1.
    tick();
    chk("stepA5_state8", state8, 8'h4B);
    chk("stepA5_rand8", {3'b0, rand8}, 8'h0B);
    next8 = 1'b0;

    // 4-bit instance: full period with next_i held high.
    next4 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("w4_state_%0d", i + 1), {4'b0, state4}, {4'b0, seq4[i]});
`ifdef LFSR_PERIOD_EN
      chk($sformatf("w4_wrap_%0d", i + 1), {7'b0, wrap4}, (i == 14) ? 8'h01 : 8'h00);
      chk($sformatf("w4_pvalid_%0d", i + 1), {7'b0, pvalid4}, (i == 14) ? 8'h01 : 8'h00);
`else
      chk($sformatf("w4_wrap_%0d", i + 1), {7'b0, wrap4}, 8'h00);
      chk($sformatf("w4_period_%0d", i + 1), {4'b0, period4}, 8'h00);
`endif
    end
`ifdef LFSR_PERIOD_EN
    chk("w4_period", {4'b0, period4}, 8'h0F);
`endif
    tick();
    chk("w4_wrap_clear", {7'b0, wrap4}, 8'h00);
    chk("w4_state_16", {4'b0, state4}, 8'h03);

    // Reset partway through a measurement, then a fresh full period.
    for (int i = 0; i < 6; i++) tick();
    next4 = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("w4_rst_state", {4'b0, state4}, 8'h01);
    chk("w4_rst_pvalid", {7'b0, pvalid4}, 8'h00);
    chk("w4_rst_period", {4'b0, period4}, 8'h00);
    next4 = 1'b1;
    exp_state = 4'h1;
    for (int i = 0; i < 15; i++) begin
      tick();
      exp_state = {exp_state[2:0], exp_state[3] ^ exp_state[0]};
      chk($sformatf("w4b_state_%0d", i + 1), {4'b0, state4}, {4'b0, exp_state});
`ifdef LFSR_PERIOD_EN
      chk($sformatf("w4b_pvalid_%0d", i + 1), {7'b0, pvalid4}, (i == 14) ? 8'h01 : 8'h00);
      chk($sformatf("w4b_period_%0d", i + 1), {4'b0, period4}, (i == 14) ? 8'h0F : 8'h00);
`else
      chk($sformatf("w4b_wrap_%0d", i + 1), {7'b0, wrap4}, 8'h00);
      chk($sformatf("w4b_pvalid_%0d", i + 1), {7'b0, pvalid4}, 8'h00);
`endif
    end
    next4 = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
